aes_128_key_expand: RTL and testbench
=====================================

AES_128_KEY_EXPAND -- requirements
Module: aes_128_key_expand

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, giving the number of expansion rounds; only 10 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-003 SHALL have port kill_n, input, 1, reset; asynchronous assert, active-low.
REQ-004 SHALL have port key_in, input, 128, cipher key; sampled only when a load is accepted.
REQ-005 SHALL have port key_load, input, 1, one-cycle load request.
REQ-006 SHALL have port busy, output, 1, high while an expansion is in progress.
REQ-007 SHALL have port en_wr, output, 1, write strobe to the key RAM; one 64-bit word per high cycle.
REQ-008 SHALL have port key_round_wr, output, 64, round-key half-word that is valid when en_wr is high.
REQ-009 SHALL have port done, output, 1, one-cycle pulse issued with the final write.
REQ-010 SHALL have port key_load_collision_irq_pulse, output, 1, one-cycle pulse raised when a key_load arrives while busy.

Function
REQ-011 SHALL accept key_load only when busy is low; accepting a load registers key_in into the round-key register rk and sets the round counter to 0.
REQ-012 SHALL implement FSM states IDLE, WR_HI, WR_LO, CALC with these transitions: IDLE->WR_HI on an accepted load; WR_HI->WR_LO; WR_LO->IDLE if round==NUM_ROUNDS, otherwise ->CALC; CALC->WR_HI.
REQ-013 SHALL, in WR_HI, drive en_wr=1 with key_round_wr=rk[127:64], and in WR_LO drive en_wr=1 with key_round_wr=rk[63:0]; en_wr SHALL be 0 in all other states.
REQ-014 SHALL, in CALC, load rk with the next round key and increment the round counter.
REQ-015 SHALL compute the next round key with w0=rk[127:96] .. w3=rk[31:0]:
 - t = SubWord(RotWord(w3)) XOR {rcon[round],24'h0}
 - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
REQ-016 SHALL use the rcon sequence 01,02,04,08,10,20,40,80,1B,36, indexed by the round being produced (1..10).
REQ-017 SHALL use the FIPS-197 S-box for SubWord, with 4 parallel combinational byte lookups.
REQ-018 SHALL meet this timing, with load accepted at edge E:
 - first en_wr high in cycle E+1
 - round r writes in cycles E+3r+1 and E+3r+2
 - 22 writes total, last write in cycle E+32
REQ-019 SHALL assert done only together with the final WR_LO write.
REQ-020 SHALL hold busy high from cycle E+1 through E+32 inclusive and drop it in cycle E+33.
REQ-021 SHALL accept a key_load in the first cycle busy is low (back-to-back expansions, no dead cycle).
REQ-022 SHALL ignore a key_load received while busy: no change to rk, round counter or write stream; key_load_collision_irq_pulse is high for exactly one cycle per colliding key_load cycle.
REQ-023 SHALL leave key_round_wr content don't-care when en_wr is low; the implementation drives 0.

Reset
REQ-024 SHALL, while kill_n is low, hold state=IDLE, round=0, rk=0, busy=0, en_wr=0, key_round_wr=0, done=0 and key_load_collision_irq_pulse=0.
REQ-025 SHALL, when kill_n is asserted mid-expansion, abort immediately with no further writes; after release the block waits for a new key_load.
REQ-026 SHALL ignore key_load in the first cycle after kill_n is released only if it is not yet synchronised; otherwise the load is accepted normally.

Structure
REQ-027 SHALL place in the shared package aes_128_pkg: the rcon table, the FSM state encodings, and the NUM_ROUNDS default.
REQ-028 SHALL instantiate sub-module aes_128_sbox (combinational 8-bit lookup) four times.
REQ-029 SHALL register all outputs directly from flops, with no combinational paths from inputs to outputs.

Verification
REQ-030 SHALL cover the FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c -> write 0 = 2b7e151628aed2a6; writes 2/3 = a0fafe1788542cb1 / 23a339392a6c7605; writes 20/21 = d014f9a8c9ee2589 / e13f0cc8b6630ca6; done coincides with write 21.
REQ-031 SHALL cover the all-zero key: round-1 words = 6263636362636363 / 6263636362636363; round-10 words = b4ef5bcb3e92e211 / 23e951cf6f8f188e.
REQ-032 SHALL cover collision: key_load pulsed at E+10 during an expansion -> one irq pulse, and the write stream is identical to the undisturbed run.
REQ-033 SHALL cover reset mid-operation: kill_n low at E+15 -> en_wr is 0 immediately; a reload afterwards produces a full, correct 22-write stream.
REQ-034 SHALL cover back-to-back loads: key_load high in cycle E+33 -> first write of the second key in E+34 and no irq pulse.

Source files
------------

// File: rtl/aes_128_pkg.sv
// Shared definitions for the AES-128 key expansion block: round count,
// FSM state encoding and the round-constant table.
package aes_128_pkg;

    // Number of expansion rounds for a 128-bit key
    localparam int AES_NUM_ROUNDS = 10;

    // Expansion FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_HI = 2'd1,
        ST_WR_LO = 2'd2,
        ST_CALC  = 2'd3
    } key_exp_state_t;

    // Round constant for the round being produced (1..10); 0 outside that range
    function automatic logic [7:0] aes_rcon(input logic [3:0] round_idx);
        logic [7:0] rc;
        case (round_idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_128_sbox.sv
// Combinational AES forward S-box: one 8-bit lookup.
module aes_128_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Table rows 0x00..0xF0, entry 0x00 in the most significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n sits at bit offset (255-n)*8, and 255-n is simply ~n
    logic [10:0] w_base;

    // Table lookup
    always_comb begin
        w_base = {~i_byte, 3'b000};
        o_byte = SBOX_TABLE[w_base +: 8];
    end

endmodule

// File: rtl/aes_128_key_expand.sv
// AES-128 key expansion engine. A load captures the cipher key, then the
// block streams all eleven round keys as 64-bit halves (high then low) to a
// key RAM, computing the next round key in a dedicated cycle between rounds.
//
// Handshake: key_load is a single-cycle request honoured only while busy is
// low; a request seen while busy is dropped and flagged on
// key_load_collision_irq_pulse. en_wr qualifies key_round_wr for exactly one
// word per high cycle; done rides on the final write. All outputs are flops.
module aes_128_key_expand
    import aes_128_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         kill_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         en_wr,
    output logic [63:0]  key_round_wr,
    output logic         done,
    output logic         key_load_collision_irq_pulse,
    output logic [1:0]   dbg_state
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    key_exp_state_t r_state;
    logic [127:0]   r_rk;
    logic [3:0]     r_round;

    logic [31:0]    w_w3;
    logic [31:0]    w_sub;
    logic [31:0]    w_t;
    logic [7:0]     w_rcon;
    logic [31:0]    w_w0n;
    logic [31:0]    w_w1n;
    logic [31:0]    w_w2n;
    logic [31:0]    w_w3n;
    logic [127:0]   w_next;

    assign w_w3 = r_rk[31:0];

    // Four byte lookups for SubWord on the last word of the current key
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_128_sbox u_sbox (
            .i_byte (w_w3[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    // Next round key: SubWord(RotWord(w3)) ^ rcon, then chained word XORs
    always_comb begin
        w_rcon = aes_rcon(4'(r_round + 4'd1));
        w_t    = {w_sub[23:16], w_sub[15:8], w_sub[7:0], w_sub[31:24]}
                 ^ {w_rcon, 24'h000000};
        w_w0n  = r_rk[127:96] ^ w_t;
        w_w1n  = r_rk[95:64]  ^ w_w0n;
        w_w2n  = r_rk[63:32]  ^ w_w1n;
        w_w3n  = r_rk[31:0]   ^ w_w2n;
        w_next = {w_w0n, w_w1n, w_w2n, w_w3n};
    end

    assign dbg_state = r_state;

    // Expansion FSM with registered write strobe, data, busy, done and irq
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            r_state                      <= ST_IDLE;
            r_rk                         <= '0;
            r_round                      <= '0;
            busy                         <= 1'b0;
            en_wr                        <= 1'b0;
            key_round_wr                 <= '0;
            done                         <= 1'b0;
            key_load_collision_irq_pulse <= 1'b0;
        end else begin
            en_wr                        <= 1'b0;
            key_round_wr                 <= '0;
            done                         <= 1'b0;
            key_load_collision_irq_pulse <= key_load & busy;
            case (r_state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (key_load) begin
                        r_rk         <= key_in;
                        r_round      <= '0;
                        r_state      <= ST_WR_HI;
                        busy         <= 1'b1;
                        en_wr        <= 1'b1;
                        key_round_wr <= key_in[127:64];
                    end
                end
                ST_WR_HI: begin
                    r_state      <= ST_WR_LO;
                    en_wr        <= 1'b1;
                    key_round_wr <= r_rk[63:0];
                    done         <= (r_round == LAST_ROUND);
                end
                ST_WR_LO: begin
                    if (r_round == LAST_ROUND) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_rk         <= w_next;
                    r_round      <= 4'(r_round + 4'd1);
                    r_state      <= ST_WR_HI;
                    en_wr        <= 1'b1;
                    key_round_wr <= w_next[127:64];
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_key_expand.sv
// Bench for aes_128_key_expand: a GF(2^8)-derived S-box and a word-level
// key schedule produce the expected write stream and write cycles; a
// negedge monitor pops and compares every write.
module tb_aes_128_key_expand;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         kill_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         busy;
    logic         en_wr;
    logic [63:0]  key_round_wr;
    logic         done;
    logic         irq;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    aes_128_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk                          (clk),
        .kill_n                       (kill_n),
        .key_in                       (key_in),
        .key_load                     (key_load),
        .busy                         (busy),
        .en_wr                        (en_wr),
        .key_round_wr                 (key_round_wr),
        .done                         (done),
        .key_load_collision_irq_pulse (irq),
        .dbg_state                    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [64:0] exp_q[$];      // {is_last, word}
    int          exp_cyc_q[$];
    logic [63:0] cap_q[$];
    int          irq_seen = 0;
    int          irq_exp = 0;
    logic [7:0]  sbox_ref[256];
    logic [64:0] mon_e;
    int          mon_ec;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Full FIPS-197 schedule; queue 22 halves with their expected cycles
    task automatic push_expected(input logic [127:0] k, input int e0);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) begin
            exp_q.push_back({1'b0, w[4*r], w[4*r+1]});
            exp_cyc_q.push_back(e0 + 3*r);
            exp_q.push_back({(r == 10), w[4*r+2], w[4*r+3]});
            exp_cyc_q.push_back(e0 + 3*r + 1);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (irq) irq_seen++;
        if (en_wr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ec = exp_cyc_q.pop_front();
                check("wr_data", key_round_wr, mon_e[63:0]);
                check("wr_done", done, mon_e[64]);
                check("wr_cycle", cyc, mon_ec);
                cap_q.push_back(key_round_wr);
            end
        end else begin
            check("idle_data_zero", key_round_wr, 0);
            check("idle_no_done", done, 0);
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic do_load(input logic [127:0] k, output int e0);
        push_expected(k, cyc + 1);
        cap_q.delete();
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        e0 = cyc;
        check("busy_start", busy, 1);
    endtask

    task automatic wait_done(input int e0);
        bit finished = 0;
        for (int i = 0; i < 80 && !finished; i++) begin
            if (cyc == e0 + 31) check("busy_last", busy, 1);
            if (cyc == e0 + 32) begin
                check("busy_drop", busy, 0);
                check("queue_drained", exp_q.size(), 0);
                finished = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!finished) check("wait_timeout", 1, 0);
    endtask

    task automatic go_to(input int target);
        for (int i = 0; i < 80 && cyc < target; i++) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        int e1;
        int irq_before;
        logic [127:0] k;

        build_sbox();

        // Reset: all outputs zero even with a load request present
        key_load = 1'b1;
        key_in   = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_en_wr", en_wr, 0);
        check("rst_data", key_round_wr, 0);
        check("rst_done", done, 0);
        check("rst_irq", irq, 0);
        check("rst_state", dbg_state, 0);
        key_load = 1'b0;
        kill_n   = 1'b1;
        @(negedge clk);

        // FIPS-197 vector
        do_load(128'h2b7e151628aed2a6abf7158809cf4f3c, e0);
        wait_done(e0);
        check("fips_count", cap_q.size(), 22);
        if (cap_q.size() == 22) begin
            check("fips_w0", cap_q[0], 64'h2b7e151628aed2a6);
            check("fips_w2", cap_q[2], 64'ha0fafe1788542cb1);
            check("fips_w3", cap_q[3], 64'h23a339392a6c7605);
            check("fips_w20", cap_q[20], 64'hd014f9a8c9ee2589);
            check("fips_w21", cap_q[21], 64'he13f0cc8b6630ca6);
        end
        @(negedge clk);

        // All-zero key
        do_load('0, e0);
        wait_done(e0);
        check("zero_count", cap_q.size(), 22);
        if (cap_q.size() == 22) begin
            check("zero_r1_hi", cap_q[2], 64'h6263636362636363);
            check("zero_r1_lo", cap_q[3], 64'h6263636362636363);
            check("zero_r10_hi", cap_q[20], 64'hb4ef5bcb3e92e211);
            check("zero_r10_lo", cap_q[21], 64'h23e951cf6f8f188e);
        end
        @(negedge clk);

        // Collision at E+10: stream must be unaffected, one irq pulse
        do_load({$urandom, $urandom, $urandom, $urandom}, e0);
        go_to(e0 + 9);
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        key_load = 1'b1;
        irq_exp++;
        @(negedge clk);
        key_load = 1'b0;
        check("irq_pulse", irq, 1);
        @(negedge clk);
        check("irq_single", irq, 0);
        wait_done(e0);
        check("collision_count", cap_q.size(), 22);
        @(negedge clk);

        // Reset at E+15: writes stop at once, then a clean reload
        do_load({$urandom, $urandom, $urandom, $urandom}, e0);
        go_to(e0 + 14);
        #1 kill_n = 1'b0;
        #1;
        check("abort_en_wr", en_wr, 0);
        check("abort_busy", busy, 0);
        check("abort_data", key_round_wr, 0);
        check("abort_state", dbg_state, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        repeat (2) @(negedge clk);
        kill_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_abort_idle", en_wr, 0);
        do_load({$urandom, $urandom, $urandom, $urandom}, e0);
        wait_done(e0);
        check("reload_count", cap_q.size(), 22);

        // Back-to-back: second load in the first busy-low cycle
        @(negedge clk);
        do_load({$urandom, $urandom, $urandom, $urandom}, e0);
        wait_done(e0);
        irq_before = irq_seen;
        do_load({$urandom, $urandom, $urandom, $urandom}, e1);
        check("b2b_accept_cycle", e1, e0 + 33);
        wait_done(e1);
        check("b2b_no_irq", irq_seen, irq_before);

        // Random keys with random idle gaps
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            k = {$urandom, $urandom, $urandom, $urandom};
            do_load(k, e0);
            wait_done(e0);
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("irq_total", irq_seen, irq_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "time limit reached");
    end

endmodule
